fifo_sync_prog: RTL and testbench
=================================

// Module: fifo_sync_prog
// PURPOSE
//  Synchronous first-word-fall-through FIFO with generalised width and depth (DEPTH>=1).
//  Adds fill-level output, programmable almost-full/almost-empty thresholds and a flush input.
//  Drop-in successor to the basic fifo on the accelerator datapath; handshake is unchanged.
// PARAMETERS
//  WIDTH   64   data word width in bits
//  DEPTH   8    number of entries, >=1; need not be a power of 2
//  LVL_W   $clog2(DEPTH+1)   derived (localparam) width of fill level and thresholds
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      synchronous active-low reset
//  w_valid       in   1      write request; data_in accepted when w_valid && !fifo_full
//  data_in       in   WIDTH  write data
//  r_ready       in   1      read request; head popped when r_ready && !fifo_empty
//  data_out      out  WIDTH  head-of-queue data (FWFT); 0 while fifo_empty
//  flush         in   1      synchronous clear of contents
//  af_thresh     in   LVL_W  almost_full threshold (quasi-static)
//  ae_thresh     in   LVL_W  almost_empty threshold (quasi-static)
//  fifo_full     out  1      level == DEPTH
//  fifo_empty    out  1      level == 0
//  almost_full   out  1      level >= af_thresh
//  almost_empty  out  1      level <= ae_thresh
//  fifo_level    out  LVL_W  current entry count, 0..DEPTH
//  overflow      out  1      [FIFO_ERR_EN] sticky: w_valid seen while fifo_full
//  underflow     out  1      [FIFO_ERR_EN] sticky: r_ready seen while fifo_empty
//  err_clr       in   1      [FIFO_ERR_EN] clears overflow/underflow
// BEHAVIOUR
//  - Reset (rst_n==0 at clk edge): wr_ptr = rd_ptr = level = 0; fifo_empty = 1; fifo_full = 0;
//    data_out = 0; fifo_level = 0; almost_* per thresholds at level 0; overflow = underflow = 0.
//    RAM contents are not reset. Reset mid-operation discards all entries in one cycle.
//  - push = w_valid & !fifo_full; pop = r_ready & !fifo_empty; flags derive from the registered level.
//  - Latency: data written at edge N is visible on data_out after edge N when the FIFO was empty;
//    no combinational path from data_in to data_out.
//  - push & pop in the same cycle: both occur, level unchanged. Pushing while full is rejected,
//    even when r_ready is high.
//  - Pointers: wrap from DEPTH-1 to 0 explicitly, without relying on a power-of-2 rollover.
//    For DEPTH==1, pointer width is 1 and the pointer stays 0.
//  - level: +1 on push only, -1 on pop only; never exceeds DEPTH and never goes below 0.
//  - flush: priority over push and pop; next cycle has pointers = level = 0.
//    Concurrent push/pop is dropped. Sticky errors are not cleared by flush.
//  - Thresholds: combinational compare against the registered level. af_thresh == 0 makes
//    almost_full constantly 1. ae_thresh >= DEPTH makes almost_empty constantly 1.
//  - data_out = empty ? 0 : mem[rd_ptr] (asynchronous read of storage).
//  - No FSM; state is {wr_ptr, rd_ptr, level, sticky errors}.
// CONFIGURATION
//  - FIFO_ERR_EN defined: overflow/underflow/err_clr ports exist.
//    A flag sets on the cycle after the offending request.
//    err_clr clears both flags; if err_clr and a new error occur in the same cycle, set wins.
//  - FIFO_ERR_EN undefined: these ports and their logic are absent. Ignored requests are silently dropped.
// STRUCTURE
//  - fifo_pkg: typedef fifo_status_t {full, empty, almost_full, almost_empty};
//    function ptr_w(depth) returns depth>1 ? $clog2(depth) : 1.
//  - Sub-module fifo_ram: WIDTH x DEPTH array, one synchronous write port, one asynchronous read port.
//  - fifo_sync_prog: pointers, level counter, flags, flush, optional error logic.
// TESTING (WIDTH=64, DEPTH=8 unless stated; scoreboard queue compares data_out on every pop)
//  1 reset -> fifo_empty=1, fifo_full=0, fifo_level=0, data_out=0.
//  2 8 pushes 0..7 with r_ready=0 -> fifo_full=1 and fifo_level=8 after the 8th edge.
//    A 9th push of 8 is dropped; pops return 0..7, then fifo_empty=1.
//  3 af_thresh=6, ae_thresh=2, push 1 per cycle:
//    almost_empty=1 at levels 0..2; almost_full=1 from level 6.
//  4 at level 4, push & pop together for 10 cycles -> level stays 4 and data order is preserved.
//    Full + push + pop together -> pop only, level 7.
//  5 fill to 5, assert flush together with w_valid -> level=0, empty=1 next cycle.
//    The concurrent word is not stored.
//  6 FIFO_ERR_EN, DEPTH=1: push while full -> overflow=1.
//    Pop while empty -> underflow=1. err_clr -> both 0. 2000 random push/pop cycles: no mismatch.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO (fifo_sync_prog).
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // A single-entry FIFO still carries a 1-bit pointer that simply stays 0.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port; contents not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    generate
        if (DEPTH == 1) begin : g_single
            // One word needs no addressing; the address inputs are always 0.
            logic [WIDTH-1:0] r_word;
            logic             w_addr_unused;

            assign w_addr_unused = ^{i_waddr, i_raddr};

            always_ff @(posedge clk) begin
                if (i_we) begin
                    r_word <= i_wdata;
                end
            end

            assign o_rdata = r_word;
        end else begin : g_array
            logic [WIDTH-1:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (i_we) begin
                    r_mem[i_waddr] <= i_wdata;
                end
            end

            assign o_rdata = r_mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_prog.sv
// First-word-fall-through synchronous FIFO with fill level, programmable thresholds and flush.
// Define FIFO_ERR_EN to add sticky overflow/underflow flags and err_clr.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_ready,
    output logic [WIDTH-1:0] data_out,
    input  logic             flush,
    input  logic [LVL_W-1:0] af_thresh,
    input  logic [LVL_W-1:0] ae_thresh,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LVL_W-1:0] fifo_level
`ifdef FIFO_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
`endif
);

    localparam int unsigned      PTR_W    = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;
    logic             w_we;
    logic [WIDTH-1:0] w_rdata;
    fifo_status_t     w_status;

    // Explicit wrap keeps non-power-of-2 depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_status              = '0;
        w_status.full         = (r_level == LVL_MAX);
        w_status.empty        = (r_level == '0);
        w_status.almost_full  = (r_level >= af_thresh);
        w_status.almost_empty = (r_level <= ae_thresh);
    end

    assign w_push = w_valid && !w_status.full;
    assign w_pop  = r_ready && !w_status.empty;
    assign w_we   = w_push && !flush && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    fifo_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(r_wr_ptr),
        .i_wdata(data_in),
        .i_raddr(r_rd_ptr),
        .o_rdata(w_rdata)
    );

    assign data_out     = w_status.empty ? '0 : w_rdata;
    assign fifo_full    = w_status.full;
    assign fifo_empty   = w_status.empty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;
    assign fifo_level   = r_level;

`ifdef FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A new error in the same cycle as err_clr keeps the flag set; flush leaves flags alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_valid && w_status.full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (r_ready && w_status.empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: DEPTH=8 directed table plus DEPTH=1 random run.
// Error-flag checks are active when FIFO_ERR_EN is defined.
module tb_fifo_sync_prog;

    localparam int unsigned W  = 64;
    localparam int unsigned D  = 8;
    localparam int unsigned LW = $clog2(D + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic          a_wv, a_rr, a_fl;
    logic [W-1:0]  a_din, a_dout;
    logic [LW-1:0] a_af, a_ae, a_lvl;
    logic          a_full, a_empty, a_afl, a_ael;

    logic          b_wv, b_rr, b_fl;
    logic [W-1:0]  b_din, b_dout;
    logic [0:0]    b_af, b_ae, b_lvl;
    logic          b_full, b_empty, b_afl, b_ael;

`ifdef FIFO_ERR_EN
    logic a_ovf, a_udf, a_eclr;
    logic b_ovf, b_udf, b_eclr;
    logic exp_bo, exp_bu;
`endif

    fifo_sync_prog #(
        .WIDTH(W),
        .DEPTH(D)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_valid     (a_wv),
        .data_in     (a_din),
        .r_ready     (a_rr),
        .data_out    (a_dout),
        .flush       (a_fl),
        .af_thresh   (a_af),
        .ae_thresh   (a_ae),
        .fifo_full   (a_full),
        .fifo_empty  (a_empty),
        .almost_full (a_afl),
        .almost_empty(a_ael),
        .fifo_level  (a_lvl)
`ifdef FIFO_ERR_EN
        ,
        .overflow    (a_ovf),
        .underflow   (a_udf),
        .err_clr     (a_eclr)
`endif
    );

    fifo_sync_prog #(
        .WIDTH(W),
        .DEPTH(1)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_valid     (b_wv),
        .data_in     (b_din),
        .r_ready     (b_rr),
        .data_out    (b_dout),
        .flush       (b_fl),
        .af_thresh   (b_af),
        .ae_thresh   (b_ae),
        .fifo_full   (b_full),
        .fifo_empty  (b_empty),
        .almost_full (b_afl),
        .almost_empty(b_ael),
        .fifo_level  (b_lvl)
`ifdef FIFO_ERR_EN
        ,
        .overflow    (b_ovf),
        .underflow   (b_udf),
        .err_clr     (b_eclr)
`endif
    );

    typedef struct {
        logic          wv;
        logic [63:0]   din;
        logic          rr;
        logic [LW-1:0] lvl;
        logic          empty;
        logic          full;
        logic          afl;
        logic          ael;
        logic [63:0]   dout;
    } vec_t;

    vec_t        tbl[$];
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    function automatic logic [63:0] dv(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // af_thresh=6, ae_thresh=2: nine pushes (last dropped), full push+pop, then drain.
    task automatic build_table();
        vec_t v;
        int   l;
        for (int i = 0; i < 9; i++) begin
            l       = (i < 8) ? i + 1 : 8;
            v.wv    = 1'b1;
            v.din   = dv(i);
            v.rr    = 1'b0;
            v.lvl   = LW'(l);
            v.empty = 1'b0;
            v.full  = (l == 8);
            v.afl   = (l >= 6);
            v.ael   = (l <= 2);
            v.dout  = dv(0);
            tbl.push_back(v);
        end
        v = '{wv: 1'b1, din: dv(9), rr: 1'b1, lvl: LW'(7), empty: 1'b0, full: 1'b0,
              afl: 1'b1, ael: 1'b0, dout: dv(1)};
        tbl.push_back(v);
        for (int k = 0; k < 7; k++) begin
            l       = 6 - k;
            v.wv    = 1'b0;
            v.din   = '0;
            v.rr    = 1'b1;
            v.lvl   = LW'(l);
            v.empty = (l == 0);
            v.full  = 1'b0;
            v.afl   = (l >= 6);
            v.ael   = (l <= 2);
            v.dout  = (l > 0) ? dv(2 + k) : 64'd0;
            tbl.push_back(v);
        end
    endtask

    task automatic step_a(input logic wv, input logic [63:0] din, input logic rr, input logic fl);
        bit push, pop;
        a_wv  = wv;
        a_din = din;
        a_rr  = rr;
        a_fl  = fl;
        push  = wv && (qa.size() < D);
        pop   = rr && (qa.size() > 0);
        if (fl) begin
            qa.delete();
        end else begin
            if (pop) void'(qa.pop_front());
            if (push) qa.push_back(din);
        end
        @(posedge clk);
        #1;
        chk("a.level", 64'(a_lvl), 64'(qa.size()));
        chk("a.data_out", a_dout, (qa.size() > 0) ? qa[0] : 64'd0);
        a_wv = 1'b0;
        a_rr = 1'b0;
        a_fl = 1'b0;
    endtask

    task automatic step_b(input logic wv, input logic [63:0] din, input logic rr,
                          input logic fl, input logic ec);
        bit push, pop;
        b_wv  = wv;
        b_din = din;
        b_rr  = rr;
        b_fl  = fl;
        push  = wv && (qb.size() == 0);
        pop   = rr && (qb.size() == 1);
`ifdef FIFO_ERR_EN
        b_eclr = ec;
        exp_bo = (wv && qb.size() == 1) ? 1'b1 : (ec ? 1'b0 : exp_bo);
        exp_bu = (rr && qb.size() == 0) ? 1'b1 : (ec ? 1'b0 : exp_bu);
`else
        if (ec) begin
            b_fl = fl;
        end
`endif
        if (fl) begin
            qb.delete();
        end else begin
            if (pop) void'(qb.pop_front());
            if (push) qb.push_back(din);
        end
        @(posedge clk);
        #1;
        chk("b.level", 64'(b_lvl), 64'(qb.size()));
        chk("b.data_out", b_dout, (qb.size() > 0) ? qb[0] : 64'd0);
        chk("b.full", 64'(b_full), 64'(qb.size() == 1));
`ifdef FIFO_ERR_EN
        chk("b.overflow", 64'(b_ovf), 64'(exp_bo));
        chk("b.underflow", 64'(b_udf), 64'(exp_bu));
        b_eclr = 1'b0;
`endif
        b_wv = 1'b0;
        b_rr = 1'b0;
        b_fl = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_wv = 1'b0; a_rr = 1'b0; a_fl = 1'b0; a_din = '0; a_af = LW'(6); a_ae = LW'(2);
        b_wv = 1'b0; b_rr = 1'b0; b_fl = 1'b0; b_din = '0; b_af = 1'b1; b_ae = 1'b0;
`ifdef FIFO_ERR_EN
        a_eclr = 1'b0; b_eclr = 1'b0; exp_bo = 1'b0; exp_bu = 1'b0;
`endif
        build_table();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.empty", 64'(a_empty), 64'd1);
        chk("reset.full", 64'(a_full), 64'd0);
        chk("reset.level", 64'(a_lvl), 64'd0);
        chk("reset.data_out", a_dout, 64'd0);
        chk("reset.almost_empty", 64'(a_ael), 64'd1);
        chk("reset.almost_full", 64'(a_afl), 64'd0);
        chk("reset.b_empty", 64'(b_empty), 64'd1);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            a_wv  = tbl[i].wv;
            a_din = tbl[i].din;
            a_rr  = tbl[i].rr;
            @(posedge clk);
            #1;
            chk($sformatf("tbl[%0d].level", i), 64'(a_lvl), 64'(tbl[i].lvl));
            chk($sformatf("tbl[%0d].empty", i), 64'(a_empty), 64'(tbl[i].empty));
            chk($sformatf("tbl[%0d].full", i), 64'(a_full), 64'(tbl[i].full));
            chk($sformatf("tbl[%0d].almost_full", i), 64'(a_afl), 64'(tbl[i].afl));
            chk($sformatf("tbl[%0d].almost_empty", i), 64'(a_ael), 64'(tbl[i].ael));
            chk($sformatf("tbl[%0d].data_out", i), a_dout, tbl[i].dout);
        end
        a_wv = 1'b0;
        a_rr = 1'b0;

        // Steady level 4 under simultaneous push and pop.
        for (int i = 0; i < 4; i++) step_a(1'b1, dv(20 + i), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step_a(1'b1, dv(30 + k), 1'b1, 1'b0);
        chk("pushpop.level4", 64'(a_lvl), 64'd4);

        // Flush beats a concurrent write.
        step_a(1'b1, dv(40), 1'b0, 1'b0);
        chk("preflush.level5", 64'(a_lvl), 64'd5);
        step_a(1'b1, dv(41), 1'b0, 1'b1);
        chk("flush.empty", 64'(a_empty), 64'd1);
        step_a(1'b0, '0, 1'b0, 1'b0);
`ifdef FIFO_ERR_EN
        chk("flush.keeps_overflow", 64'(a_ovf), 64'd1);
        chk("a.underflow_clear", 64'(a_udf), 64'd0);
`endif
        step_a(1'b1, dv(50), 1'b0, 1'b0);
        chk("fwft.latency", a_dout, dv(50));

        // Threshold boundaries.
        a_af = '0;
        #1;
        chk("af0.almost_full", 64'(a_afl), 64'd1);
        for (int i = 0; i < 7; i++) step_a(1'b1, dv(60 + i), 1'b0, 1'b0);
        a_ae = LW'(8);
        #1;
        chk("ae8.almost_empty", 64'(a_ael), 64'd1);
        a_ae = LW'(7);
        #1;
        chk("ae7.almost_empty", 64'(a_ael), 64'd0);
        a_af = LW'(8);
        #1;
        chk("af8.almost_full", 64'(a_afl), 64'd1);
        a_af = LW'(6);
        a_ae = LW'(2);

        // Reset mid-operation drops everything in one cycle.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete();
        chk("midreset.level", 64'(a_lvl), 64'd0);
        chk("midreset.empty", 64'(a_empty), 64'd1);
        chk("midreset.data_out", a_dout, 64'd0);

        // DEPTH=1: overflow, underflow, clear, set-wins-over-clear.
        step_b(1'b1, dv(100), 1'b0, 1'b0, 1'b0);
        step_b(1'b1, dv(101), 1'b0, 1'b0, 1'b0);
        step_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step_b(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step_b(1'b1, dv(102), 1'b0, 1'b0, 1'b0);
        step_b(1'b1, dv(103), 1'b0, 1'b0, 1'b1);
        step_b(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            step_b(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
